// File: rtl/nes_video_pkg.sv
// Shared NES video types and the 64-entry NES master palette (24-bit RGB).
package nes_video_pkg;

  localparam int unsigned NES_W = 256;
  localparam int unsigned NES_H = 240;

  typedef logic [5:0] palette_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] NES_PALETTE [64] = '{
    24'h747474, 24'h24188C, 24'h0000A8, 24'h44009C, 24'h8C0074, 24'hA80010, 24'hA40000, 24'h7C0800,
    24'h402C00, 24'h004400, 24'h005000, 24'h003C14, 24'h183C5C, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0070EC, 24'h2038EC, 24'h8000F0, 24'hBC00BC, 24'hE40058, 24'hD82800, 24'hC84C0C,
    24'h887000, 24'h009400, 24'h00A800, 24'h009038, 24'h008088, 24'h000000, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'h3CBCFC, 24'h5C94FC, 24'hCC88FC, 24'hF478FC, 24'hFC74B4, 24'hFC7460, 24'hFC9838,
    24'hF0BC3C, 24'h80D010, 24'h4CDC48, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA8E4FC, 24'hC4D4FC, 24'hD4C8FC, 24'hFCC4FC, 24'hFCC4D8, 24'hFCBCB0, 24'hFCD8A8,
    24'hFCE4A0, 24'hE0FCA0, 24'hA8F0BC, 24'hB0FCCC, 24'h9CFCF0, 24'hC4C4C4, 24'h000000, 24'h000000
  };

  function automatic rgb_t palette_lookup(input palette_idx_t idx);
    return rgb_t'(NES_PALETTE[idx]);
  endfunction

endpackage

// File: rtl/nes_palette_rom.sv
// Registered 64x24 NES palette lookup, one dclk of latency.
module nes_palette_rom
  import nes_video_pkg::*;
(
  input  logic         dclk,
  input  logic         Reset,
  input  palette_idx_t idx,
  output rgb_t         rgb
);

  always_ff @(posedge dclk) begin
    if (Reset) begin
      rgb <= '0;
    end else begin
      rgb <= palette_lookup(idx);
    end
  end

endmodule

// File: rtl/nes_line_doubler.sv
// Ping-pong NES scanline buffer replayed twice per NES line onto VGA timing.
// Optional macro SCANLINE_EN halves RGB intensity on odd VGA lines.
module nes_line_doubler
  import nes_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        dclk,
  input  logic        Reset,
  input  logic        pix_valid,
  input  logic [7:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [5:0]  pix_index,
  input  logic [10:0] DrawX,
  input  logic [10:0] DrawY,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  localparam int unsigned PIPE_LAT = 2;
  localparam logic [10:0] H_LIMIT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIMIT  = 11'(V_ACTIVE);

  logic [5:0]   line_mem [2*NES_W];
  logic [7:0]   tag [2];
  logic [1:0]   tag_valid;
  logic         wr_en;

  logic         rb;
  logic [7:0]   nl;
  logic         line_start;
  logic         line_hit;
  logic         line_ok;
  logic         line_ok_cur;

  palette_idx_t ram_q;
  logic         ok_d1, ok_d2;
  logic         xact_d1, xact_d2;
  logic [2:0]   sync_dly [PIPE_LAT];
  rgb_t         pal_rgb;
  logic         show;

  assign wr_en = pix_valid && (pix_y < 8'(NES_H));

  // Buffer RAM is deliberately left out of reset.
  always_ff @(posedge dclk) begin
    if (wr_en) begin
      line_mem[{pix_y[0], pix_x}] <= pix_index;
    end
  end

  always_ff @(posedge dclk) begin
    if (Reset) begin
      tag_valid <= '0;
      tag[0]    <= '0;
      tag[1]    <= '0;
    end else if (wr_en && (pix_x == 8'hFF)) begin
      tag[pix_y[0]]       <= pix_y;
      tag_valid[pix_y[0]] <= 1'b1;
    end
  end

  // The check result is forwarded at DrawX==0 so pixel 0 already sees it.
  always_comb begin
    rb          = DrawY[1];
    nl          = DrawY[8:1];
    line_start  = (DrawX == '0) && (DrawY < V_LIMIT);
    line_hit    = tag_valid[rb] && (tag[rb] == nl);
    line_ok_cur = line_start ? line_hit : line_ok;
  end

  // Separate block from the RAM write so a colliding read returns old data.
  always_ff @(posedge dclk) begin
    if (Reset) begin
      ram_q <= '0;
    end else begin
      ram_q <= line_mem[{rb, DrawX[7:0]}];
    end
  end

  always_ff @(posedge dclk) begin
    if (Reset) begin
      line_ok        <= 1'b0;
      ok_d1          <= 1'b0;
      ok_d2          <= 1'b0;
      xact_d1        <= 1'b0;
      xact_d2        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        sync_dly[i] <= '0;
      end
    end else begin
      if (line_start) begin
        line_ok <= line_hit;
      end
      ok_d1       <= line_ok_cur;
      ok_d2       <= ok_d1;
      xact_d1     <= (DrawX < H_LIMIT);
      xact_d2     <= xact_d1;
      sync_dly[0] <= {blank_in, vs_in, hs_in};
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        sync_dly[i] <= sync_dly[i-1];
      end
      underrun <= line_start && !line_hit;
      if (line_start && !line_hit && (underrun_count != '1)) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

  nes_palette_rom u_palette_rom (
    .dclk  (dclk),
    .Reset (Reset),
    .idx   (ram_q),
    .rgb   (pal_rgb)
  );

  assign show = sync_dly[PIPE_LAT-1][2] && ok_d2 && xact_d2;

`ifdef SCANLINE_EN
  logic odd_d1, odd_d2;

  always_ff @(posedge dclk) begin
    if (Reset) begin
      odd_d1 <= 1'b0;
      odd_d2 <= 1'b0;
    end else begin
      odd_d1 <= DrawY[0];
      odd_d2 <= odd_d1;
    end
  end

  always_comb begin
    vga_r = '0;
    vga_g = '0;
    vga_b = '0;
    if (show) begin
      vga_r = odd_d2 ? {1'b0, pal_rgb.r[7:1]} : pal_rgb.r;
      vga_g = odd_d2 ? {1'b0, pal_rgb.g[7:1]} : pal_rgb.g;
      vga_b = odd_d2 ? {1'b0, pal_rgb.b[7:1]} : pal_rgb.b;
    end
  end
`else
  always_comb begin
    vga_r = '0;
    vga_g = '0;
    vga_b = '0;
    if (show) begin
      vga_r = pal_rgb.r;
      vga_g = pal_rgb.g;
      vga_b = pal_rgb.b;
    end
  end
`endif

  assign vga_hs    = sync_dly[PIPE_LAT-1][0];
  assign vga_vs    = sync_dly[PIPE_LAT-1][1];
  assign vga_blank = sync_dly[PIPE_LAT-1][2];

endmodule

// File: tb/tb_nes_line_doubler.sv
// Randomized bench for nes_line_doubler against a per-cycle behavioural model.
module tb_nes_line_doubler;

  localparam logic [23:0] PAL [64] = '{
    24'h747474, 24'h24188C, 24'h0000A8, 24'h44009C, 24'h8C0074, 24'hA80010, 24'hA40000, 24'h7C0800,
    24'h402C00, 24'h004400, 24'h005000, 24'h003C14, 24'h183C5C, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0070EC, 24'h2038EC, 24'h8000F0, 24'hBC00BC, 24'hE40058, 24'hD82800, 24'hC84C0C,
    24'h887000, 24'h009400, 24'h00A800, 24'h009038, 24'h008088, 24'h000000, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'h3CBCFC, 24'h5C94FC, 24'hCC88FC, 24'hF478FC, 24'hFC74B4, 24'hFC7460, 24'hFC9838,
    24'hF0BC3C, 24'h80D010, 24'h4CDC48, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA8E4FC, 24'hC4D4FC, 24'hD4C8FC, 24'hFCC4FC, 24'hFCC4D8, 24'hFCBCB0, 24'hFCD8A8,
    24'hFCE4A0, 24'hE0FCA0, 24'hA8F0BC, 24'hB0FCCC, 24'h9CFCF0, 24'hC4C4C4, 24'h000000, 24'h000000
  };

  logic        dclk = 1'b0;
  logic        Reset = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_x = '0;
  logic [7:0]  pix_y = '0;
  logic [5:0]  pix_index = '0;
  logic [10:0] DrawX = '0;
  logic [10:0] DrawY = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_in = 1'b0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank;
  logic        underrun;
  logic [15:0] underrun_count;

  always #5 dclk = ~dclk;

  nes_line_doubler dut (
    .dclk           (dclk),
    .Reset          (Reset),
    .pix_valid      (pix_valid),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_index      (pix_index),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .hs_in          (hs_in),
    .vs_in          (vs_in),
    .blank_in       (blank_in),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .vga_hs         (vga_hs),
    .vga_vs         (vga_vs),
    .vga_blank      (vga_blank),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  sync;
  } oexp_t;

  typedef struct {
    logic        u;
    logic [15:0] cnt;
  } uexp_t;

  oexp_t oq[$];
  uexp_t uq[$];

  // Model: per-bank pixel contents, the NES line each bank holds (-1 = none).
  int mem_m [2][256];
  int tag_m [2];
  bit ok_m;
  int cnt_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input int ncyc);
    oexp_t z;
    uexp_t uz;
    Reset     = 1'b1;
    pix_valid = 1'b0;
    @(posedge dclk); #1;
    check("rst_rgb",  {vga_r, vga_g, vga_b}, 0);
    check("rst_sync", {vga_hs, vga_vs, vga_blank}, 0);
    check("rst_urun", {underrun, underrun_count}, 0);
    repeat (ncyc - 1) @(posedge dclk);
    #1;
    Reset = 1'b0;
    tag_m[0] = -1;
    tag_m[1] = -1;
    ok_m  = 1'b0;
    cnt_m = 0;
    oq.delete();
    uq.delete();
    z.rgb = '0;
    z.sync = '0;
    uz.u = 1'b0;
    uz.cnt = '0;
    oq.push_back(z);
    oq.push_back(z);
    uq.push_back(uz);
  endtask

  // One dclk: check outputs due now, drive inputs, then advance the model.
  task automatic step(input bit wv, input int wx, input int wy, input int wi,
                      input int dx, input int dy, input bit hs, input bit vs, input bit bl);
    oexp_t oe;
    uexp_t ue;
    logic [23:0] c;
    bit up;
    if (oq.size() >= 2) begin
      oe = oq.pop_front();
      check("rgb",  {vga_r, vga_g, vga_b}, oe.rgb);
      check("sync", {vga_hs, vga_vs, vga_blank}, oe.sync);
    end
    if (uq.size() >= 1) begin
      ue = uq.pop_front();
      check("underrun", underrun, ue.u);
      check("ucount", underrun_count, ue.cnt);
    end
    pix_valid = wv;
    pix_x     = 8'(wx);
    pix_y     = 8'(wy);
    pix_index = 6'(wi);
    DrawX     = 11'(dx);
    DrawY     = 11'(dy);
    hs_in     = hs;
    vs_in     = vs;
    blank_in  = bl;
    up = 1'b0;
    if (dx == 0 && dy < 480) begin
      ok_m = (tag_m[(dy / 2) % 2] == dy / 2);
      up = !ok_m;
      if (up && cnt_m < 65535) cnt_m++;
    end
    c = '0;
    if (bl && ok_m && dx < 256) begin
      c = PAL[mem_m[(dy / 2) % 2][dx]];
`ifdef SCANLINE_EN
      if (dy % 2 == 1) c = {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
`endif
    end
    oe.rgb  = c;
    oe.sync = {hs, vs, bl};
    oq.push_back(oe);
    ue.u   = up;
    ue.cnt = 16'(cnt_m);
    uq.push_back(ue);
    if (wv && wy < 240) begin
      mem_m[wy % 2][wx] = wi;
      if (wx == 255) tag_m[wy % 2] = wy;
    end
    @(posedge dclk); #1;
  endtask

  task automatic vga_line(input int dy, input int nx);
    for (int x = 0; x < nx; x++) begin
      step(1'b0, 0, 0, 0, x, dy, !(x >= 272 && x < 312), !(dy >= 490 && dy < 492),
           (dy < 480) && (x < 256));
    end
  endtask

  task automatic write_line(input int ny, input bit rnd);
    for (int x = 0; x < 256; x++) begin
      step(1'b1, x, ny, rnd ? int'($urandom_range(0, 63)) : x % 64, x, 500, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic vga_line_rand(input int dy, input int wy);
    bit wv, hs, vs, bl;
    int wx;
    for (int x = 0; x < 341; x++) begin
      wv = ($urandom_range(0, 3) == 0);
      hs = ($urandom_range(0, 9) != 0);
      vs = ($urandom_range(0, 9) != 0);
      bl = (x < 256) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
      wx = (x < 256) ? x : int'($urandom_range(0, 255));
      step(wv, wx, wy, int'($urandom_range(0, 63)), x, dy, hs, vs, bl);
    end
  endtask

  initial begin
    int ny;
    do_reset(3);

    // Empty buffer: black line, one underrun.
    vga_line(0, 341);
    check("cnt_first_line", underrun_count, 1);

    // Fill both banks, then replay NES lines 0 and 1.
    write_line(0, 1'b0);
    write_line(1, 1'b1);
    vga_line(0, 341);
    vga_line(1, 341);
    vga_line(2, 341);
    vga_line(3, 341);

    // Bank 0 now holds line 2: DrawY 0 must mismatch, DrawY 4 must hit.
    write_line(2, 1'b1);
    vga_line(0, 341);
    vga_line(4, 341);
    vga_line(5, 341);

    // Reset in the middle of a line invalidates both tags.
    vga_line(4, 120);
    do_reset(2);
    vga_line(4, 341);
    check("cnt_after_reset", underrun_count, 1);

    write_line(4, 1'b1);
    write_line(5, 1'b1);
    vga_line(8, 341);
    vga_line(10, 341);

    for (int k = 0; k < 14; k++) begin
      ny = int'($urandom_range(0, 239));
      write_line(ny, 1'b1);
      if ($urandom_range(0, 3) == 0)
        vga_line_rand(int'($urandom_range(0, 479)), int'($urandom_range(0, 255)));
      else
        vga_line_rand(2 * ny + int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 0, 300, 500, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
